// File: rtl/key_found_arbiter_pkg.sv
// Shared types and constants for the RC4 key-search found arbiter.
package key_arb_pkg;

  localparam int DEF_NUM_CORES     = 4;
  localparam int DEF_LOG_NUM_CORES = 2;
  localparam int WD_W              = 25;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SELECT = 3'd2,
    PULL   = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef logic [DEF_LOG_NUM_CORES-1:0] core_idx_t;

endpackage

// File: rtl/key_found_arbiter_if.sv
// Core-control and pull-stage bundle between the found arbiter and its neighbours.
interface key_found_arbiter_if
  import key_arb_pkg::*;
#(
  parameter int NUM_CORES     = DEF_NUM_CORES,
  parameter int LOG_NUM_CORES = DEF_LOG_NUM_CORES
);

  logic                     start;
  logic [NUM_CORES-1:0]     core_done;
  logic [NUM_CORES-1:0]     core_found;
  logic                     cores_start;
  logic                     cores_stop;
  logic                     pull_enable;
  logic [LOG_NUM_CORES-1:0] pull_addr;
  logic                     search_done;
  logic                     key_found;
  logic                     timed_out;

  modport slave (
    input  start, core_done, core_found,
    output cores_start, cores_stop, pull_enable, pull_addr,
           search_done, key_found, timed_out
  );

  modport master (
    output start, core_done, core_found,
    input  cores_start, cores_stop, pull_enable, pull_addr,
           search_done, key_found, timed_out
  );

endinterface

// File: rtl/key_found_arbiter_lowest_set_encoder.sv
// Combinational priority encoder: index of the lowest set bit, plus an any-set flag.
module lowest_set_encoder #(
  parameter int NUM_CORES     = 4,
  parameter int LOG_NUM_CORES = 2
) (
  input  logic [NUM_CORES-1:0]     vec_i,
  output logic [LOG_NUM_CORES-1:0] index_o,
  output logic                     any_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index_o = '0;
    any_o   = |vec_i;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      index_o = vec_i[i] ? LOG_NUM_CORES'(i) : index_o;
    end
  end

endmodule

// File: rtl/key_found_arbiter.sv
// Launches the cracking cores, picks the winning core and strobes the key pull stage.
// Optional watchdog enabled by defining KEY_ARB_TIMEOUT_EN.
module key_found_arbiter
  import key_arb_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int LOG_NUM_CORES  = DEF_LOG_NUM_CORES,
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input  logic                clk,
  input  logic                reset,
  key_found_arbiter_if.slave  arb_if
);

  if (LOG_NUM_CORES != ((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)) begin : g_bad_log
    $error("LOG_NUM_CORES does not match NUM_CORES");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** WD_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of watchdog range");
  end

  state_e                   state_q, state_d;
  logic [NUM_CORES-1:0]     hit_s, hit_q, hit_d, enc_in_s;
  logic [LOG_NUM_CORES-1:0] enc_idx_s;
  logic                     enc_any_s, all_done_s, expire_s;
  logic                     cores_start_q, cores_start_d;
  logic                     cores_stop_q, cores_stop_d;
  logic                     pull_enable_q, pull_enable_d;
  logic [LOG_NUM_CORES-1:0] pull_addr_q, pull_addr_d;
  logic                     search_done_q, search_done_d;
  logic                     key_found_q, key_found_d;

  assign hit_s      = arb_if.core_done & arb_if.core_found;
  assign all_done_s = &arb_if.core_done;
  // One encoder serves both the RUN hit test (live hits) and SELECT (latched hits).
  assign enc_in_s   = (state_q == SELECT) ? hit_q : hit_s;

  lowest_set_encoder #(
    .NUM_CORES     (NUM_CORES),
    .LOG_NUM_CORES (LOG_NUM_CORES)
  ) u_enc (
    .vec_i   (enc_in_s),
    .index_o (enc_idx_s),
    .any_o   (enc_any_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d       = state_q;
    hit_d         = hit_q;
    cores_start_d = 1'b0;
    cores_stop_d  = cores_stop_q;
    pull_enable_d = 1'b0;
    pull_addr_d   = pull_addr_q;
    search_done_d = search_done_q;
    key_found_d   = key_found_q;
    case (state_q)
      IDLE, DONE: begin
        if (arb_if.start) begin
          state_d       = RUN;
          cores_start_d = 1'b1;
          cores_stop_d  = 1'b0;
          search_done_d = 1'b0;
          key_found_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        // A hit beats both all-done and watchdog expiry in the same cycle.
        if (enc_any_s) begin
          state_d      = SELECT;
          hit_d        = hit_s;
          cores_stop_d = 1'b1;
        end else if (all_done_s || expire_s) begin
          state_d       = DONE;
          cores_stop_d  = 1'b1;
          search_done_d = 1'b1;
          key_found_d   = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      SELECT: begin
        state_d       = PULL;
        pull_addr_d   = enc_idx_s;
        pull_enable_d = 1'b1;
      end
      PULL: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d       = DONE;
        search_done_d = 1'b1;
        key_found_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hit_q         <= '0;
      cores_start_q <= 1'b0;
      cores_stop_q  <= 1'b0;
      pull_enable_q <= 1'b0;
      pull_addr_q   <= '0;
      search_done_q <= 1'b0;
      key_found_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hit_q         <= hit_d;
      cores_start_q <= cores_start_d;
      cores_stop_q  <= cores_stop_d;
      pull_enable_q <= pull_enable_d;
      pull_addr_q   <= pull_addr_d;
      search_done_q <= search_done_d;
      key_found_q   <= key_found_d;
    end
  end

`ifdef KEY_ARB_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timed_out_q, timed_out_d;

  // Expiry is seen in the last RUN cycle so DONE lands exactly TIMEOUT_CYCLES after RUN entry.
  assign expire_s = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog count and timeout flag next-state.
  always_comb begin
    wd_d        = wd_q;
    timed_out_d = timed_out_q;
    if (state_q == RUN) begin
      wd_d        = wd_q + WD_W'(1);
      timed_out_d = expire_s & ~enc_any_s & ~all_done_s;
    end else if (((state_q == IDLE) || (state_q == DONE)) && arb_if.start) begin
      wd_d        = '0;
      timed_out_d = 1'b0;
    end else begin
      wd_d = wd_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q        <= '0;
      timed_out_q <= 1'b0;
    end else begin
      wd_q        <= wd_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign arb_if.timed_out = timed_out_q;
`else
  assign expire_s         = 1'b0;
  assign arb_if.timed_out = 1'b0;
`endif

  assign arb_if.cores_start = cores_start_q;
  assign arb_if.cores_stop  = cores_stop_q;
  assign arb_if.pull_enable = pull_enable_q;
  assign arb_if.pull_addr   = pull_addr_q;
  assign arb_if.search_done = search_done_q;
  assign arb_if.key_found   = key_found_q;

endmodule

// File: tb/tb_key_found_arbiter.sv
// Self-checking bench for key_found_arbiter: event-timestamp model plus directed literal checks.
module tb_key_found_arbiter;

  localparam int NC  = 4;
  localparam int LNC = 2;
`ifdef KEY_ARB_TIMEOUT_EN
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 16777216;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_found_arbiter_if #(.NUM_CORES(NC), .LOG_NUM_CORES(LNC)) bus ();

  key_found_arbiter #(
    .NUM_CORES      (NC),
    .LOG_NUM_CORES  (LNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_if (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: search outcome expressed as timestamps of start, first hit and no-hit end.
  bit m_valid = 1'b0;
  bit m_started = 1'b0;
  int m_start = -100;
  int m_hit = -1;
  int m_hit_idx = 0;
  int m_end = -1;
  bit m_end_to = 1'b0;
  int m_prev_addr = 0;

  always @(negedge clk) begin : model_cmp
    int c;
    bit hit_done, end_done, accepting, searching;
    logic [NC-1:0] h;
    c         = cyc;
    hit_done  = (m_hit >= 0) && (c >= m_hit + 4);
    end_done  = (m_end >= 0) && (c >= m_end + 1);
    if (m_valid) begin
      chk("m_cores_start", 32'(bus.cores_start), 32'(m_started && (c == m_start + 1)));
      chk("m_cores_stop", 32'(bus.cores_stop), 32'(((m_hit >= 0) && (c >= m_hit + 1)) || end_done));
      chk("m_pull_enable", 32'(bus.pull_enable), 32'((m_hit >= 0) && (c == m_hit + 2)));
      chk("m_pull_addr", 32'(bus.pull_addr),
          32'(((m_hit >= 0) && (c >= m_hit + 2)) ? m_hit_idx : m_prev_addr));
      chk("m_search_done", 32'(bus.search_done), 32'(hit_done || end_done));
      chk("m_key_found", 32'(bus.key_found), 32'(hit_done));
      chk("m_timed_out", 32'(bus.timed_out), 32'(end_done && m_end_to));
    end
    h = bus.core_done & bus.core_found;
    if (reset) begin
      m_valid     = 1'b1;
      m_started   = 1'b0;
      m_start     = -100;
      m_hit       = -1;
      m_end       = -1;
      m_end_to    = 1'b0;
      m_prev_addr = 0;
    end else if (m_valid) begin
      accepting = !m_started || hit_done || end_done;
      searching = m_started && (c >= m_start + 1) && (m_hit < 0) && (m_end < 0);
      if (accepting && bus.start) begin
        if (m_hit >= 0) m_prev_addr = m_hit_idx;
        m_started = 1'b1;
        m_start   = c;
        m_hit     = -1;
        m_end     = -1;
        m_end_to  = 1'b0;
      end else if (searching) begin
        if (h != '0) begin
          m_hit = c;
          for (int i = NC - 1; i >= 0; i--) if (h[i]) m_hit_idx = i;
        end else if (&bus.core_done) begin
          m_end = c;
        end else if (TO_EN && (c - (m_start + 1) == TO - 1)) begin
          m_end    = c;
          m_end_to = 1'b1;
        end
      end
    end
  end

  task automatic to_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic launch(input int t);
    to_cycle(t);
    bus.start      = 1'b1;
    bus.core_done  = '0;
    bus.core_found = '0;
    to_cycle(t + 1);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.core_done  = '0;
    bus.core_found = '0;
    to_cycle(3);
    reset = 1'b0;

    // Launch pulse
    launch(5);
    at_neg(6);
    chk("t1_cores_start", 32'(bus.cores_start), 32'd1);
    chk("t1_cores_stop", 32'(bus.cores_stop), 32'd0);
    chk("t1_search_done", 32'(bus.search_done), 32'd0);
    at_neg(7);
    chk("t1_start_once", 32'(bus.cores_start), 32'd0);

    // Single hit on core 2 at cycle 15
    to_cycle(15);
    bus.core_done  = 4'b0100;
    bus.core_found = 4'b0100;
    at_neg(16);
    chk("t2_stop", 32'(bus.cores_stop), 32'd1);
    chk("t2_pe_early", 32'(bus.pull_enable), 32'd0);
    at_neg(17);
    chk("t2_pe", 32'(bus.pull_enable), 32'd1);
    chk("t2_addr", 32'(bus.pull_addr), 32'd2);
    at_neg(18);
    chk("t2_pe_late", 32'(bus.pull_enable), 32'd0);
    chk("t2_sd_early", 32'(bus.search_done), 32'd0);
    at_neg(19);
    chk("t2_sd", 32'(bus.search_done), 32'd1);
    chk("t2_kf", 32'(bus.key_found), 32'd1);

    // Simultaneous hits on 1 and 3, found-without-done ignored, later core 0 ignored
    launch(22);
    to_cycle(24);
    bus.core_found = 4'b0001;
    to_cycle(25);
    bus.core_found = 4'b0000;
    to_cycle(26);
    bus.core_done  = 4'b1010;
    bus.core_found = 4'b1010;
    to_cycle(28);
    bus.core_done  = 4'b1011;
    bus.core_found = 4'b1011;
    at_neg(28);
    chk("t3_pe", 32'(bus.pull_enable), 32'd1);
    chk("t3_addr", 32'(bus.pull_addr), 32'd1);
    at_neg(30);
    chk("t3_sd", 32'(bus.search_done), 32'd1);
    chk("t3_addr_hold", 32'(bus.pull_addr), 32'd1);

    // All cores done, nothing found
    launch(33);
    to_cycle(36);
    bus.core_done = 4'b0011;
    to_cycle(38);
    bus.core_done = 4'b1111;
    at_neg(38);
    chk("t4_sd_early", 32'(bus.search_done), 32'd0);
    at_neg(39);
    chk("t4_sd", 32'(bus.search_done), 32'd1);
    chk("t4_kf", 32'(bus.key_found), 32'd0);
    chk("t4_stop", 32'(bus.cores_stop), 32'd1);
    chk("t4_addr_kept", 32'(bus.pull_addr), 32'd1);

    // Hit arrives with the final done
    launch(42);
    to_cycle(45);
    bus.core_done = 4'b0111;
    to_cycle(47);
    bus.core_done  = 4'b1111;
    bus.core_found = 4'b1000;
    at_neg(48);
    chk("t5_not_done", 32'(bus.search_done), 32'd0);
    at_neg(49);
    chk("t5_addr", 32'(bus.pull_addr), 32'd3);
    at_neg(51);
    chk("t5_kf", 32'(bus.key_found), 32'd1);

    // Reset while in PULL, then a clean search
    launch(54);
    to_cycle(57);
    bus.core_done  = 4'b0001;
    bus.core_found = 4'b0001;
    to_cycle(59);
    reset = 1'b1;
    at_neg(59);
    chk("t6_pe_before", 32'(bus.pull_enable), 32'd1);
    to_cycle(60);
    reset          = 1'b0;
    bus.core_done  = '0;
    bus.core_found = '0;
    at_neg(60);
    chk("t6_rst_stop", 32'(bus.cores_stop), 32'd0);
    chk("t6_rst_pe", 32'(bus.pull_enable), 32'd0);
    chk("t6_rst_addr", 32'(bus.pull_addr), 32'd0);
    chk("t6_rst_sd", 32'(bus.search_done), 32'd0);
    launch(62);
    to_cycle(66);
    bus.core_done  = 4'b0100;
    bus.core_found = 4'b0100;
    at_neg(70);
    chk("t6_sd", 32'(bus.search_done), 32'd1);
    chk("t6_addr", 32'(bus.pull_addr), 32'd2);

    // Long search with no hits (watchdog case when enabled)
    launch(73);
    at_neg(89);
    chk("t7_sd_early", 32'(bus.search_done), 32'd0);
    at_neg(90);
`ifdef KEY_ARB_TIMEOUT_EN
    chk("t7_to", 32'(bus.timed_out), 32'd1);
    chk("t7_sd", 32'(bus.search_done), 32'd1);
    chk("t7_kf", 32'(bus.key_found), 32'd0);
`else
    chk("t7_no_to", 32'(bus.timed_out), 32'd0);
    chk("t7_running", 32'(bus.search_done), 32'd0);
`endif
    launch(93);
    at_neg(94);
`ifdef KEY_ARB_TIMEOUT_EN
    chk("t7_restart", 32'(bus.cores_start), 32'd1);
    chk("t7_to_clr", 32'(bus.timed_out), 32'd0);
`else
    chk("t7_start_ignored", 32'(bus.cores_start), 32'd0);
`endif
    to_cycle(96);
    bus.core_done = 4'b1111;
    at_neg(97);
    chk("t7_end_sd", 32'(bus.search_done), 32'd1);
    chk("t7_end_to", 32'(bus.timed_out), 32'd0);
    to_cycle(100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
